// File: rtl/spike_delay_sched_if.sv
// rtl/spike_delay_sched_if.sv - port bundle between the scheduler and its shared 1-bit simple-dual-port RAM
interface spike_delay_sched_if #(
  parameter int AW = 12
);
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic          ram_dina;
  logic [AW-1:0] ram_addrb;
  logic          ram_doutb;

  modport master (output ram_wea, ram_addra, ram_dina, ram_addrb, input ram_doutb);
  modport slave  (input ram_wea, ram_addra, ram_dina, ram_addrb, output ram_doutb);
endinterface

// File: rtl/spike_delay_sched.sv
// rtl/spike_delay_sched.sv - per-channel programmable spike delay loops time-multiplexed on one 1-bit RAM
// Optional macro SPIKE_OR_DIRECT_EN: OR the undelayed spike into spike_out.
module spike_delay_sched #(
  parameter int  NCH = 4,
  parameter int  SEG = 1024,
  parameter int  DW  = 10,
  parameter int  AW  = 12,
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                tick,
  input  logic [NCH-1:0]      spike_in,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [DW-1:0]       cfg_delay,
  spike_delay_sched_if.master ram,
  output logic [NCH-1:0]      spike_out,
  output logic                done,
  output logic                busy,
  output logic                overrun
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [DW:0]   SEG_W   = (DW+1)'(SEG);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH-1);

  state_t          r_state, w_next;
  logic [CW-1:0]   r_ch;
  logic [DW-1:0]   r_wptr;
  logic [DW-1:0]   r_delay  [NCH];
  logic [DW-1:0]   r_shadow [NCH];
  logic [DW-1:0]   r_fill   [NCH];
  logic [NCH-1:0]  r_sin_q, r_dly_bit, r_spike_out;
  logic            r_done, r_overrun;

  logic [AW-1:0]   w_base;
  logic [DW:0]     w_rsum, w_rptr, w_wp1;
  logic [DW-1:0]   w_clamp;
  logic [NCH-1:0]  w_held, w_new;

  assign w_base  = AW'(r_ch) * AW'(SEG);
  // Read pointer is (wptr - delay) mod SEG, kept non-negative by adding SEG first.
  assign w_rsum  = {1'b0, r_wptr} + SEG_W - {1'b0, r_delay[r_ch]};
  assign w_rptr  = (w_rsum >= SEG_W) ? (w_rsum - SEG_W) : w_rsum;
  assign w_wp1   = {1'b0, r_wptr} + (DW+1)'(1);
  assign w_clamp = ({1'b0, cfg_delay} >= SEG_W) ? DW'(SEG-1) : cfg_delay;

  assign spike_out = r_spike_out;
  assign done      = r_done;
  assign overrun   = r_overrun;
  assign busy      = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    ram.ram_wea     = 1'b0;
    ram.ram_addra   = '0;
    ram.ram_dina    = 1'b0;
    ram.ram_addrb   = '0;
    case (r_state)
      S_IDLE:  if (tick) w_next = S_RUN;
      S_RUN: begin
        ram.ram_wea   = 1'b1;
        ram.ram_addra = w_base + AW'(r_wptr);
        ram.ram_dina  = r_sin_q[r_ch];
        ram.ram_addrb = w_base + AW'(w_rptr);
        if (r_ch == LAST_CH) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last channel's read data arrives during DRAIN, so it is taken straight from the RAM.
  always_comb begin
    w_held          = r_dly_bit;
    w_held[NCH-1]   = ram.ram_doutb;
    w_new           = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_delay[c] == '0) begin
        w_new[c] = r_sin_q[c];
      end else begin
        w_new[c] = (r_fill[c] < r_delay[c]) ? 1'b0 : w_held[c];
`ifdef SPIKE_OR_DIRECT_EN
        w_new[c] = w_new[c] | r_sin_q[c];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ch        <= '0;
      r_wptr      <= '0;
      r_sin_q     <= '0;
      r_dly_bit   <= '0;
      r_spike_out <= '0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_delay[c]  <= '0;
        r_shadow[c] <= '0;
        r_fill[c]   <= '0;
      end
    end else begin
      r_done <= (r_state == S_DRAIN);
      if (cfg_we) r_shadow[cfg_ch] <= w_clamp;
      if (tick && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (tick) begin
          r_sin_q <= spike_in;
          r_ch    <= '0;
          for (int c = 0; c < NCH; c++) begin
            r_delay[c] <= r_shadow[c];
            if (r_shadow[c] != r_delay[c]) r_fill[c] <= '0;
          end
        end
        S_RUN: begin
          if (r_ch != '0) r_dly_bit[r_ch - CW'(1)] <= ram.ram_doutb;
          if (r_ch != LAST_CH) r_ch <= r_ch + CW'(1);
        end
        S_DRAIN: begin
          r_dly_bit[NCH-1] <= ram.ram_doutb;
          r_spike_out      <= w_new;
          r_wptr           <= (w_wp1 == SEG_W) ? '0 : w_wp1[DW-1:0];
          for (int c = 0; c < NCH; c++)
            if (r_fill[c] < r_delay[c]) r_fill[c] <= r_fill[c] + DW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_delay_sched.sv
// tb/tb_spike_delay_sched.sv - self-checking bench: RAM model plus tick-level history reference model
`timescale 1ns/1ps
module tb_spike_delay_sched;
  localparam int NCH = 4, SEG = 1024, DW = 11, AW = 12, CW = 2;

  logic           clk = 1'b0, reset_n = 1'b0, tick = 1'b0, cfg_we = 1'b0;
  logic [NCH-1:0] spike_in = '0;
  logic [CW-1:0]  cfg_ch = '0;
  logic [DW-1:0]  cfg_delay = '0;
  logic [NCH-1:0] spike_out;
  logic           done, busy, overrun;

  spike_delay_sched_if #(.AW(AW)) ram_if ();

  spike_delay_sched #(.NCH(NCH), .SEG(SEG), .DW(DW), .AW(AW)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .spike_in(spike_in),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_delay(cfg_delay), .ram(ram_if.master),
    .spike_out(spike_out), .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_if.ram_wea) mem[ram_if.ram_addra] <= ram_if.ram_dina;
    ram_if.ram_doutb <= mem[ram_if.ram_addrb];
  end

  // Reference: a delayed spike is simply the spike_in vector recorded d ticks ago.
  int             dly_m [NCH];
  int             shd_m [NCH];
  int             fill_m[NCH];
  logic [NCH-1:0] hist[$];
  logic [NCH-1:0] exp_m;

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin dly_m[c] = 0; shd_m[c] = 0; fill_m[c] = 0; end
    hist.delete();
  endfunction

  function automatic void m_cfg(input int ch, input int val);
    shd_m[ch] = (val >= SEG) ? SEG - 1 : val;
  endfunction

  function automatic void m_tick(input logic [NCH-1:0] sin);
    logic [NCH-1:0] old;
    logic e;
    int d;
    hist.push_back(sin);
    for (int c = 0; c < NCH; c++) begin
      if (shd_m[c] != dly_m[c]) begin dly_m[c] = shd_m[c]; fill_m[c] = 0; end
      d = dly_m[c];
      if (d == 0) e = sin[c];
      else begin
        e = 1'b0;
        if (fill_m[c] >= d) begin old = hist[hist.size() - 1 - d]; e = old[c]; end
`ifdef SPIKE_OR_DIRECT_EN
        e = e | sin[c];
`endif
      end
      exp_m[c] = e;
      if (fill_m[c] < d) fill_m[c]++;
    end
  endfunction

  int total = 0, bad = 0, n_coll = 0;
  logic [NCH-1:0] last_out;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk)
    if (reset_n && ram_if.ram_wea && ram_if.ram_addra == ram_if.ram_addrb &&
        dly_m[int'(ram_if.ram_addra) / SEG] != 0)
      n_coll++;

  task automatic do_cfg(input int ch, input int val);
    cfg_we = 1'b1; cfg_ch = CW'(ch); cfg_delay = DW'(val);
    m_cfg(ch, val);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // cfg_at: -1 none, 0 same cycle as tick, k>0 during cycle T+k; extra_at likewise for a second tick.
  task automatic do_tick(input logic [NCH-1:0] sin, input int extra_at, input int cfg_at,
                         input int cch, input int cval);
    int k;
    bit seen;
    tick = 1'b1; spike_in = sin;
    if (cfg_at == 0) begin cfg_we = 1'b1; cfg_ch = CW'(cch); cfg_delay = DW'(cval); end
    m_tick(sin);
    if (cfg_at >= 0) m_cfg(cch, cval);
    k = 0; seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      tick = (k == extra_at);
      if (k == cfg_at) begin cfg_we = 1'b1; cfg_ch = CW'(cch); cfg_delay = DW'(cval); end
      else cfg_we = 1'b0;
      if (done) seen = 1'b1;
    end
    tick = 1'b0; cfg_we = 1'b0;
    chk("done_latency", 64'(k), 64'(6));
    last_out = spike_out;
    chk("spike_out_model", 64'(spike_out), 64'(exp_m));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_reset();
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [NCH-1:0] sin;
    logic [NCH-1:0] exp;
  } vec_t;
  vec_t tab[8];

`ifdef SPIKE_OR_DIRECT_EN
  localparam logic [NCH-1:0] T0_EXP = 4'b0001;
  localparam int             ECHO_CNT = 2;
`else
  localparam logic [NCH-1:0] T0_EXP = 4'b0000;
  localparam int             ECHO_CNT = 1;
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ones[NCH], lastn[NCH], want_last[NCH];
    logic [NCH-1:0] s;
    logic           w1;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 1'($urandom);
    m_reset();

    tab[0] = '{4'b0001, T0_EXP};
    tab[1] = '{4'b0000, 4'b0000};
    tab[2] = '{4'b0100, 4'b0100};
    tab[3] = '{4'b0000, 4'b0000};
    tab[4] = '{4'b0000, 4'b0000};
    tab[5] = '{4'b0000, 4'b0001};
    tab[6] = '{4'b0010, 4'b0010};
    tab[7] = '{4'b0000, 4'b0000};

    #23;
    chk("rst_spike_out", 64'(spike_out), 64'(0));
    chk("rst_done",      64'(done),      64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_overrun",   64'(overrun),   64'(0));
    chk("rst_wea",       64'(ram_if.ram_wea),   64'(0));
    chk("rst_addra",     64'(ram_if.ram_addra), 64'(0));
    chk("rst_dina",      64'(ram_if.ram_dina),  64'(0));
    chk("rst_addrb",     64'(ram_if.ram_addrb), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single-channel delay 5, table-driven.
    do_cfg(0, 5);
    for (int i = 0; i < 8; i++) begin
      do_tick(tab[i].sin, -1, -1, 0, 0);
      chk($sformatf("tab_tick%0d", i), 64'(last_out), 64'(tab[i].exp));
    end

    // Four channels 0/1/3/2000(clamped), across the wptr wrap.
    do_reset();
    do_cfg(0, 0); do_cfg(1, 1); do_cfg(2, 3); do_cfg(3, 2000);
    n_coll = 0;
    for (int c = 0; c < NCH; c++) begin ones[c] = 0; lastn[c] = -1; end
    for (int n = 0; n < 1100; n++) begin
      do_tick((n == 0) ? 4'b1111 : 4'b0000, -1, -1, 0, 0);
      for (int c = 0; c < NCH; c++) if (last_out[c]) begin ones[c]++; lastn[c] = n; end
    end
    want_last[0] = 0; want_last[1] = 1; want_last[2] = 3; want_last[3] = 1023;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("echo_tick_ch%0d", c), 64'(lastn[c]), 64'(want_last[c]));
      chk($sformatf("echo_cnt_ch%0d", c), 64'(ones[c]), 64'((c == 0) ? 1 : ECHO_CNT));
    end
    chk("no_addr_collision", 64'(n_coll), 64'(0));

    // Delay change 4 -> 2 on channel 1 while RUN is in progress.
    do_reset();
    do_cfg(1, 4);
    for (int n = 0; n < 6; n++) do_tick(NCH'($urandom), -1, -1, 0, 0);
    do_tick(NCH'($urandom), -1, 2, 1, 2);
    for (int n = 0; n < 2; n++) begin
      s = NCH'($urandom);
      do_tick(s, -1, -1, 0, 0);
`ifdef SPIKE_OR_DIRECT_EN
      w1 = s[1];
`else
      w1 = 1'b0;
`endif
      chk($sformatf("fill_mask_ch1_%0d", n), 64'(last_out[1]), 64'(w1));
    end
    for (int n = 0; n < 6; n++) do_tick(NCH'($urandom), -1, -1, 0, 0);

    // Tick while busy is dropped and overrun sticks.
    chk("overrun_clear", 64'(overrun), 64'(0));
    do_tick(NCH'($urandom), 3, -1, 0, 0);
    chk("overrun_set", 64'(overrun), 64'(1));
    do_cfg(2, 7); do_cfg(2, 3);
    for (int n = 0; n < 6; n++) do_tick(NCH'($urandom), -1, -1, 0, 0);
    chk("overrun_sticky", 64'(overrun), 64'(1));

    // Randomized configuration and spikes against the reference.
    for (int n = 0; n < 300; n++) begin
      int r, ca, cch, cv;
      r   = $urandom_range(0, 5);
      cch = $urandom_range(0, NCH - 1);
      cv  = ($urandom_range(0, 9) == 0) ? 1500 : $urandom_range(0, 12);
      ca  = -1;
      if (r == 0) do_cfg(cch, cv);
      else if (r == 1) ca = 0;
      else if (r == 2) ca = $urandom_range(1, 5);
      do_tick(NCH'($urandom), -1, ca, cch, cv);
    end

    // Reset in the middle of RUN.
    tick = 1'b1; spike_in = 4'b1111;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrun_busy",      64'(busy),      64'(0));
    chk("midrun_spike_out", 64'(spike_out), 64'(0));
    chk("midrun_overrun",   64'(overrun),   64'(0));
    chk("midrun_done",      64'(done),      64'(0));
    chk("midrun_wea",       64'(ram_if.ram_wea), 64'(0));
    m_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_cfg(0, 3);
    for (int n = 0; n < 5; n++) begin
      do_tick(4'b1111, -1, -1, 0, 0);
`ifdef SPIKE_OR_DIRECT_EN
      w1 = 1'b1;
`else
      w1 = (n >= 3);
`endif
      chk($sformatf("post_reset_ch0_%0d", n), 64'(last_out[0]), 64'(w1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_delay_sched.md
Name: spike_delay_sched

Overview:
- Time-multiplexed controller that shares one simple-dual-port 1-bit block RAM among NCH spike channels.
- Each channel gets its own programmable loop delay, counted in neuron ticks.
- On every neuron tick it sequences, per channel, one RAM write of the current spike and one RAM read of the spike from `delay` ticks earlier.
- Sits between the neuron/motor-unit spike outputs and the downstream spikecnt blocks; it replaces the hand-coded single-channel write_index/read_index delay loop.

Parameters:
- NCH, 4, number of spike channels sharing the RAM.
- SEG, 1024, per-channel ring segment length in words; channel c occupies RAM addresses c*SEG .. c*SEG+SEG-1.
- DW, 10, width of the delay value and of the segment pointer; requires 2**DW >= SEG.
- AW, 12, RAM address width; requires 2**AW >= NCH*SEG.

Ports:
- clk  in  1  rawclk-domain clock; all logic is on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-clk pulse per neuron step (synchronised neuron_clk edge).
- spike_in  in  NCH  undelayed spikes, sampled on the tick cycle.
- cfg_we  in  1  delay-write strobe.
- cfg_ch  in  clog2(NCH)  channel selected by cfg_we.
- cfg_delay  in  DW  new delay in ticks for cfg_ch.
- ram_wea  out  1  RAM port-A write enable.
- ram_addra  out  AW  RAM write address.
- ram_dina  out  1  RAM write data.
- ram_addrb  out  AW  RAM read address.
- ram_doutb  in  1  RAM read data; 1-cycle read latency.
- spike_out  out  NCH  delayed spikes; held from one done to the next.
- done  out  1  one-clk pulse when spike_out has been updated for this tick.
- busy  out  1  high while the FSM is not in IDLE.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Outputs: ram_wea=0, ram_addra=0, ram_dina=0, ram_addrb=0, spike_out=0, done=0, busy=0, overrun=0.
  - Internal state: wptr=0; every delay=0 and fill=0; the spike_in latch is cleared; FSM goes to IDLE.
- FSM states: IDLE -> RUN -> DRAIN -> IDLE.
- IDLE:
  - tick=1 latches spike_in into sin_q, applies pending shadow delays, sets ch=0 and moves to RUN.
- RUN, one cycle per channel ch = 0..NCH-1:
  - ram_wea=1, ram_addra=ch*SEG+wptr, ram_dina=sin_q[ch].
  - ram_addrb = ch*SEG + ((wptr - delay[ch]) mod SEG).
  - After ch=NCH-1, move to DRAIN.
- Data capture:
  - ram_doutb is valid one cycle after its address was issued.
  - It is captured into the channel's delayed bit during RUN cycles 2..NCH and during DRAIN.
- DRAIN, one cycle:
  - Captures the last channel and writes spike_out.
  - Pulses done and ram_wea=0; wptr <= (wptr+1 == SEG) ? 0 : wptr+1; returns to IDLE.
- Latency: the tick cycle is T. RUN spans T+1..T+NCH, DRAIN is T+NCH+1, and done plus the updated spike_out are visible at T+NCH+2 (T+6 for NCH=4).
- Per-channel output rule for spike_out[c]:
  - delay[c]==0: bypass, spike_out[c]=sin_q[c] and the RAM read is ignored.
  - fill[c] < delay[c]: spike_out[c]=0, masking uninitialised RAM.
  - Otherwise: spike_out[c] = captured RAM bit.
- fill[c] increments once per tick in DRAIN and saturates at delay[c].
- Delay configuration:
  - cfg_we writes a shadow register in any state.
  - Values >= SEG are clamped to SEG-1, so the write and read addresses never collide.
  - The shadow is applied only in IDLE on tick, never mid-sequence.
  - Applying a changed value clears fill[c]. Re-writing the same value does not clear it.
- Overrun:
  - A tick while busy is dropped: no state change, and overrun is set.
  - overrun clears only on reset.
- Simultaneous events:
  - cfg_we in the same cycle as tick: the new value lands in the shadow and is applied at the next tick.
  - Two cfg_we writes to the same channel before a tick: the last one wins.
- wptr wraps SEG-1 -> 0. The read pointer uses modulo-SEG subtraction, so no off-by-one at the wrap.
- Reset mid-RUN: abort immediately and clear everything; the RAM contents are stale but masked by fill=0.

Optional Feature:
- Macro: SPIKE_OR_DIRECT_EN.
- Defined: spike_out[c] = delayed bit | sin_q[c], merging the short- and long-latency loops inside the block.
- Undefined: spike_out carries the delayed spike only.
- The bypass and fill rules are unchanged in both builds. With the macro defined and delay 0, the result is sin_q[c].

Test Plan:
- Single channel, delay[0]=5, spike_in[0] pulsed on tick 0 only -> spike_out[0]=1 only after tick 5's done; all other ticks give 0; done occurs 6 clks after each tick.
- Four channels with delays 0/1/3/SEG-1 and spike_in=4'b1111 on tick 0 -> channel 0 high after tick 0, channel 1 after tick 1, channel 2 after tick 3, channel 3 after tick 1023, each exactly once.
- Program cfg_delay=2000 with SEG=1024 -> delay clamps to 1023; run 1100 ticks across the wptr wrap -> no write/read address collision and the correct echo at tick 1023.
- Change delay[1] 4 -> 2 during RUN with a spike every tick -> the old delay is still used for the current tick; spike_out[1]=0 for the next 2 ticks (fill cleared), then follows spike_in[1] delayed by 2.
- Tick asserted at T+3 while busy -> that tick is ignored, overrun=1 and stays 1 until reset_n low; wptr advances only once.
- reset_n low mid-RUN, then release -> all outputs 0, busy=0, fill=0; after the first post-reset tick with delay=3, spike_out stays 0 for 3 ticks. With SPIKE_OR_DIRECT_EN defined, spike_in=1 appears on spike_out immediately.
